// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan controller: segment bit
// positions, the unlit segment pattern and the scan FSM state type.
package seg7_pkg;

  // Bit positions inside a {g,f,e,d,c,b,a} segment vector
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  // All segments unlit, in active-high (logical) form
  localparam logic [6:0] SEG_OFF = 7'b000_0000;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to seven-segment decoder. Output is active-high (1 = lit),
// ordered {g,f,e,d,c,b,a}.
module hex7seg
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure lookup of the glyph for each hex digit
  always_comb begin
    seg = SEG_OFF;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit seven-segment display.
// New values land in a pending buffer and are promoted to the displayed
// copy only at frame end, so a frame never mixes old and new digits.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 100000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    zero_suppress,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load_valid,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(SCAN_DIV - BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);

  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

  localparam logic [NUM_DIGITS-1:0] AN_DARK  = {NUM_DIGITS{AN_INV}};
  localparam logic [6:0]            SEG_DARK = {7{SEG_INV}};
  localparam logic [NUM_DIGITS-1:0] DIGIT0   = NUM_DIGITS'(1);

  scan_state_t               state;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;

  logic [4*NUM_DIGITS-1:0]   active_val;
  logic [NUM_DIGITS-1:0]     active_dp;
  logic [4*NUM_DIGITS-1:0]   pending_val;
  logic [NUM_DIGITS-1:0]     pending_dp;
  logic                      pending_full;

  logic                      frame_end;
  logic [3:0]                cur_nibble;
  logic [6:0]                dec_seg;
  logic [NUM_DIGITS-1:0]     lead_zero;
  logic                      blank_digit;
  logic [6:0]                seg_lit;
  logic                      dp_lit;
  logic [NUM_DIGITS-1:0]     digit_sel;

  assign load_ready = ~pending_full;

  assign frame_end = enable && (state == DRIVE) && (idx == LAST_IDX) &&
                     (cnt == DRIVE_LAST);

  assign cur_nibble = active_val[4*idx +: 4];

  hex7seg u_dec (
    .nibble (cur_nibble),
    .seg    (dec_seg)
  );

  // lead_zero[i] is set when digit i and every digit above it hold zero
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (active_val[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (active_val[4*i +: 4] == 4'h0);
    end
  end

  assign blank_digit = zero_suppress && (idx != '0) && lead_zero[idx];
  assign seg_lit     = blank_digit ? SEG_OFF : dec_seg;
  assign dp_lit      = ~blank_digit & active_dp[idx];
  assign digit_sel   = DIGIT0 << idx;

  // Scan FSM with registered pin outputs driven from the current slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      an         <= AN_DARK;
      seg        <= SEG_DARK;
      dp         <= SEG_INV;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= '0;
      an         <= AN_DARK;
      seg        <= SEG_DARK;
      dp         <= SEG_INV;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= frame_end;
      if (state == DRIVE) begin
        an  <= digit_sel ^ AN_DARK;
        seg <= seg_lit ^ SEG_DARK;
        dp  <= dp_lit ^ SEG_INV;
      end else begin
        an  <= AN_DARK;
        seg <= SEG_DARK;
        dp  <= SEG_INV;
      end
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt   <= '0;
            state <= DRIVE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DRIVE: begin
          if (cnt == DRIVE_LAST) begin
            cnt   <= '0;
            state <= BLANK;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= BLANK;
        end
      endcase
    end
  end

  // Pending/active double buffer: capture when empty, promote at frame end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_val  <= '0;
      pending_dp   <= '0;
      pending_full <= 1'b0;
      active_val   <= '0;
      active_dp    <= '0;
    end else begin
      if (frame_end && pending_full) begin
        active_val   <= pending_val;
        active_dp    <= pending_dp;
        pending_full <= 1'b0;
      end
      if (load_valid && !pending_full) begin
        pending_val  <= value_in;
        pending_dp   <= dp_in;
        pending_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with a short scan (8-cycle slots,
// 2 blank cycles). A second instance with active-high segments runs in
// lockstep on the same inputs.
module tb_seg7_scan_ctrl;

  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_2 = 7'b0100100;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_4 = 7'b0011001;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_6 = 7'b0000010;
  localparam logic [6:0] S_7 = 7'b1111000;
  localparam logic [6:0] S_8 = 7'b0000000;
  localparam logic [6:0] S_9 = 7'b0010000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_F = 7'b0001110;
  localparam logic [6:0] S_X = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        zero_suppress = 1'b0;
  logic [15:0] value_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load_valid = 1'b0;

  logic        load_ready, dp, frame_tick;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        load_ready_hi, dp_hi, frame_tick_hi;
  logic [3:0]  an_hi;
  logic [6:0]  seg_hi;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .zero_suppress(zero_suppress),
    .value_in(value_in), .dp_in(dp_in), .load_valid(load_valid),
    .load_ready(load_ready), .an(an), .seg(seg), .dp(dp),
    .frame_tick(frame_tick)
  );

  seg7_scan_ctrl #(
    .NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2),
    .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(1)
  ) dut_hi (
    .clk(clk), .rst(rst), .enable(enable), .zero_suppress(zero_suppress),
    .value_in(value_in), .dp_in(dp_in), .load_valid(load_valid),
    .load_ready(load_ready_hi), .an(an_hi), .seg(seg_hi), .dp(dp_hi),
    .frame_tick(frame_tick_hi)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one value for capture, then confirm the buffer reports full
  task automatic applyStimulus(input logic [15:0] val, input logic [3:0] dpv);
    value_in   = val;
    dp_in      = dpv;
    load_valid = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    checkOutput("load_ready_after_capture", {31'd0, load_ready}, 32'd0);
  endtask

  task automatic waitFrameTick();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    checkOutput("frame_tick_wait", {31'd0, frame_tick}, 32'd1);
  endtask

  // Called on the cycle a frame_tick is visible; checks the whole next frame
  task automatic checkFrame(input logic [27:0] segs, input logic [3:0] dplit,
                            input logic ready_k1);
    int s, p;
    logic [3:0] e_an;
    logic [6:0] e_seg, h_seg;
    logic e_dp, h_dp, e_tick;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput("load_ready_frame_start", {31'd0, load_ready}, {31'd0, ready_k1});
        load_valid = 1'b0;
      end
      s = (k - 1) / 8;
      p = (k - 1) % 8;
      if (p >= 2) begin
        e_an  = ~(4'b0001 << s);
        e_seg = segs[7*s +: 7];
        e_dp  = ~dplit[s];
      end else begin
        e_an  = 4'hF;
        e_seg = S_X;
        e_dp  = 1'b1;
      end
      h_seg  = ~e_seg;
      h_dp   = ~e_dp;
      e_tick = (k == 32);
      checkOutput($sformatf("an k=%0d", k), {28'd0, an}, {28'd0, e_an});
      checkOutput($sformatf("seg k=%0d", k), {25'd0, seg}, {25'd0, e_seg});
      checkOutput($sformatf("dp k=%0d", k), {31'd0, dp}, {31'd0, e_dp});
      checkOutput($sformatf("an_hi k=%0d", k), {28'd0, an_hi}, {28'd0, e_an});
      checkOutput($sformatf("seg_hi k=%0d", k), {25'd0, seg_hi}, {25'd0, h_seg});
      checkOutput($sformatf("dp_hi k=%0d", k), {31'd0, dp_hi}, {31'd0, h_dp});
      checkOutput($sformatf("frame_tick k=%0d", k), {31'd0, frame_tick}, {31'd0, e_tick});
    end
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    checkOutput("rst_an", {28'd0, an}, 32'hF);
    checkOutput("rst_seg", {25'd0, seg}, 32'h7F);
    checkOutput("rst_dp", {31'd0, dp}, 32'd1);
    checkOutput("rst_seg_hi", {25'd0, seg_hi}, 32'h00);
    checkOutput("rst_frame_tick", {31'd0, frame_tick}, 32'd0);
    checkOutput("rst_load_ready", {31'd0, load_ready}, 32'd1);
    rst    = 1'b0;
    enable = 1'b1;

    // Basic scan of 12AF
    applyStimulus(16'h12AF, 4'b0000);
    waitFrameTick();
    checkOutput("ready_after_promote", {31'd0, load_ready}, 32'd1);
    checkFrame({S_1, S_2, S_A, S_F}, 4'b0000, 1'b1);

    // Leading-zero suppression
    zero_suppress = 1'b1;
    applyStimulus(16'h0042, 4'b0000);
    waitFrameTick();
    checkFrame({S_X, S_X, S_4, S_2}, 4'b0000, 1'b1);
    applyStimulus(16'h0000, 4'b0000);
    waitFrameTick();
    checkFrame({S_X, S_X, S_X, S_0}, 4'b0000, 1'b1);
    zero_suppress = 1'b0;

    // Backpressure while pending is full
    applyStimulus(16'h3456, 4'b0000);
    value_in   = 16'h789A;
    dp_in      = 4'b0000;
    load_valid = 1'b1;
    @(negedge clk);
    checkOutput("ready_low_while_full", {31'd0, load_ready}, 32'd0);
    waitFrameTick();
    checkOutput("ready_after_promote_A", {31'd0, load_ready}, 32'd1);
    checkFrame({S_3, S_4, S_5, S_6}, 4'b0000, 1'b0);
    checkFrame({S_7, S_8, S_9, S_A}, 4'b0000, 1'b1);

    // Disable mid-DRIVE of digit 2, then re-enable
    repeat (20) @(negedge clk);
    checkOutput("an_pre_disable", {28'd0, an}, 32'hB);
    enable = 1'b0;
    @(negedge clk);
    checkOutput("dis_an", {28'd0, an}, 32'hF);
    checkOutput("dis_seg", {25'd0, seg}, 32'h7F);
    checkOutput("dis_dp", {31'd0, dp}, 32'd1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      checkOutput($sformatf("dis_hold_an i=%0d", i), {28'd0, an}, 32'hF);
      checkOutput($sformatf("dis_no_tick i=%0d", i), {31'd0, frame_tick}, 32'd0);
    end
    enable = 1'b1;
    checkFrame({S_7, S_8, S_9, S_A}, 4'b0000, 1'b1);

    // Asynchronous reset between clock edges discards the pending value
    applyStimulus(16'h1111, 4'b1111);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_an", {28'd0, an}, 32'hF);
    checkOutput("arst_seg", {25'd0, seg}, 32'h7F);
    checkOutput("arst_dp", {31'd0, dp}, 32'd1);
    checkOutput("arst_load_ready", {31'd0, load_ready}, 32'd1);
    checkOutput("arst_frame_tick", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    zero_suppress = 1'b1;
    waitFrameTick();
    checkFrame({S_X, S_X, S_X, S_0}, 4'b0000, 1'b1);
    zero_suppress = 1'b0;

    // Decimal point on digit 2, both segment polarities
    applyStimulus(16'h8888, 4'b0100);
    waitFrameTick();
    checkFrame({S_8, S_8, S_8, S_8}, 4'b0100, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for an NUM_DIGITS-digit common-anode seven-segment display.
- Holds a frame-coherent copy of the value to show and cycles through digit slots; each slot is a blanking gap followed by drive time.
- Per slot it selects one nibble, decodes it through hex7seg, applies leading-zero suppression and decimal point, and drives registered anode/segment pins.
- Sits between the application (speed/state display) and the board display pins.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8)
SCAN_DIV, 100000, clock cycles per digit slot (blank + drive); must be > BLANK_CYCLES
BLANK_CYCLES, 1000, cycles at slot start with all anodes off (anti-ghosting); >= 1
SEG_ACTIVE_LOW, 1, 1 = seg/dp pins active-low (hex7seg output inverted), 0 = active-high
AN_ACTIVE_LOW, 1, 1 = anode pins active-low

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
enable  in  1  1 = scan; 0 = display dark, scan restarts at digit 0
zero_suppress  in  1  1 = blank leading zero digits
value_in  in  4*NUM_DIGITS  hex value; nibble i shown on digit i (digit 0 = rightmost)
dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
load_valid  in  1  value_in/dp_in valid for capture
load_ready  out  1  1 = pending buffer empty, capture accepted
an  out  NUM_DIGITS  anode enables, polarity per AN_ACTIVE_LOW
seg  out  7  {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW
dp  out  1  decimal point, polarity per SEG_ACTIVE_LOW
frame_tick  out  1  one-cycle pulse at end of each full frame

Behaviour:
- Reset (async, immediate): state BLANK, slot counter 0, digit index 0, active value/dp = 0, pending empty. Outputs: an all inactive, seg/dp unlit, frame_tick 0, load_ready 1.
- Handshake: load_ready = ~pending_full. On load_valid & load_ready, capture value_in/dp_in into pending and set pending_full. Capture never writes the active register directly, so there is no tearing.
- Frame end = last cycle of DRIVE for digit NUM_DIGITS-1. On that cycle:
  - frame_tick asserts (registered; visible the following cycle).
  - If pending_full, pending is copied to active and pending_full clears, so load_ready rises the next cycle.
  - A capture cannot occur on the same cycle because load_ready is low while pending is full.
- FSM states:
  - BLANK: anodes off; count BLANK_CYCLES, then go to DRIVE with counter reset.
  - DRIVE: anode[idx] on; count SCAN_DIV-BLANK_CYCLES. Then idx = (idx==NUM_DIGITS-1) ? 0 : idx+1 and go to BLANK.
- Slot counter width: clog2(SCAN_DIV). Each slot is exactly SCAN_DIV cycles; a frame is NUM_DIGITS*SCAN_DIV cycles.
- Digit data: nibble = active[4*idx +: 4] feeds hex7seg; the result is inverted if SEG_ACTIVE_LOW. dp = active_dp[idx].
- Zero suppression: when zero_suppress=1, digit i (i>0) is blanked (seg and dp unlit) if nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is never suppressed.
- Output timing: an/seg/dp are registered from current state/idx, giving 1-cycle latency. In BLANK, seg/dp are also driven unlit.
- enable=0: on the next clock, state becomes BLANK, idx and counter reset to 0, and outputs go dark. No frame_tick and no pending transfer occur while disabled. Captures are still accepted until pending is full. When enable returns to 1, scanning restarts at BLANK of digit 0.
- Reset mid-frame: scan and pending buffer are discarded immediately.

Decomposition:
- Shared package seg7_pkg: segment bit-order constants (SEG_A..SEG_G), SEG_OFF pattern, FSM state enum {BLANK, DRIVE}.
- One sub-module: the existing hex7seg decoder, instantiated once (combinational, between mux and output register).
- Counter and FSM stay in this module.

Test Plan:
Parameters for bench: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2, both polarities active-low.
1. Reset, enable=1, load 16'h12AF, dp=4'b0000 → after first frame_tick the next frame shows per-digit seg F=0001110, A=0001000, 2=0100100, 1=1111001 with an=1110/1101/1011/0111. Each slot has 2 cycles of an=1111 then 6 cycles driven, and frame_tick occurs every 32 cycles.
2. Load 16'h0042 with zero_suppress=1 → digits 3 and 2 show seg=1111111, digit 1 shows 4 (0011001), digit 0 shows 2. Load 16'h0000 → only digit 0 lit, showing 0 (1000000).
3. Load A, then assert load_valid with B while pending is full → load_ready=0 and B is ignored. A appears only after frame_tick, then load_ready returns to 1 and B is accepted.
4. Deassert enable mid-DRIVE of digit 2 → next cycle an=1111, seg=1111111, no frame_tick. Re-enable → first driven anode is digit 0 after 2 blank cycles.
5. Assert rst asynchronously mid-slot (between clock edges) → an=1111, seg/dp unlit, and load_ready=1 immediately. Active value is 0, so the display shows 0000 (or only digit 0 with zero_suppress).
6. dp_in=4'b0100 with SEG_ACTIVE_LOW=0 variant → dp=1 only during digit 2 DRIVE, and seg for 8 = 1111111.
